// File: rtl/mem_stage_sram_ctrl_if.sv
// MEM-stage pipeline and external SRAM signals of the data-memory controller.
// master = pipeline/SRAM side, slave = controller.
interface mem_stage_sram_ctrl_if #(
  parameter int WORD_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 18
);
  logic                       MEM_R_EN;
  logic                       MEM_W_EN;
  logic [WORD_WIDTH-1:0]      ALU_Res;
  logic [WORD_WIDTH-1:0]      Val_Rm;
  logic                       ready;
  logic [WORD_WIDTH-1:0]      rdata;
  logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
  logic [15:0]                sram_dq_out;
  logic                       sram_dq_oe;
  logic                       sram_we_n;
  logic [15:0]                sram_dq_in;

  modport master (
    output MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, sram_dq_in,
    input  ready, rdata, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport slave (
    input  MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, sram_dq_in,
    output ready, rdata, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: each 32-bit load/store becomes two 16-bit SRAM phases of WAIT_CYCLES each.
// Optional MEM_ADDR_OFFSET_EN maps data memory at byte 1024 (eff = ALU_Res - 1024).
module mem_stage_sram_ctrl #(
  parameter int WORD_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 18,
  parameter int WAIT_CYCLES     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_stage_sram_ctrl_if.slave  bus
);
  localparam int         SAW  = SRAM_ADDR_WIDTH;
  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [SAW-2:0]        r_base;
  logic [15:0]           r_wdata_hi;
  logic                  r_is_wr;
  logic [15:0]           r_low_half;
  logic [WORD_WIDTH-1:0] r_rdata;
  logic [SAW-1:0]        r_sram_addr;
  logic [15:0]           r_dq_out;
  logic                  r_dq_oe;
  logic                  r_we_n;

  logic [WORD_WIDTH-1:0] w_eff;
  logic [SAW-2:0]        w_base;
  logic                  w_req;
  logic [3:0]            w_cnt_nxt;
  logic                  w_last;
  logic                  w_strobe_first;
  logic                  w_strobe_cont;
  logic                  w_unused_bits;

`ifdef MEM_ADDR_OFFSET_EN
  assign w_eff = bus.ALU_Res - WORD_WIDTH'(1024);
`else
  assign w_eff = bus.ALU_Res;
`endif

  assign w_base    = w_eff[SAW:2];
  assign w_req     = bus.MEM_R_EN | bus.MEM_W_EN;
  assign w_cnt_nxt = r_cnt + 4'd1;
  assign w_last    = (r_cnt == LAST);
  // Write strobe is dropped on the final cycle of each phase for setup/hold margin.
  assign w_strobe_first = bus.MEM_W_EN && (LAST != 4'd0);
  assign w_strobe_cont  = r_is_wr && (w_cnt_nxt != LAST);
  assign w_unused_bits  = ^{w_eff[WORD_WIDTH-1:SAW+1], w_eff[1:0]};

  assign bus.ready       = (r_state == DONE) || ((r_state == IDLE) && !w_req);
  assign bus.rdata       = r_rdata;
  assign bus.sram_addr   = r_sram_addr;
  assign bus.sram_dq_out = r_dq_out;
  assign bus.sram_dq_oe  = r_dq_oe;
  assign bus.sram_we_n   = r_we_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_base      <= '0;
      r_wdata_hi  <= 16'd0;
      r_is_wr     <= 1'b0;
      r_low_half  <= 16'd0;
      r_rdata     <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= 16'd0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state     <= LOW;
            r_cnt       <= 4'd0;
            r_base      <= w_base;
            r_wdata_hi  <= bus.Val_Rm[31:16];
            r_is_wr     <= bus.MEM_W_EN;
            r_sram_addr <= {w_base, 1'b0};
            r_dq_out    <= bus.Val_Rm[15:0];
            r_we_n      <= !w_strobe_first;
            r_dq_oe     <= w_strobe_first;
          end
        end
        LOW: begin
          if (w_last) begin
            r_low_half  <= bus.sram_dq_in;
            r_state     <= HIGH;
            r_cnt       <= 4'd0;
            r_sram_addr <= {r_base, 1'b1};
            r_dq_out    <= r_wdata_hi;
            r_we_n      <= !(r_is_wr && (LAST != 4'd0));
            r_dq_oe     <= r_is_wr && (LAST != 4'd0);
          end else begin
            r_cnt   <= w_cnt_nxt;
            r_we_n  <= !w_strobe_cont;
            r_dq_oe <= w_strobe_cont;
          end
        end
        HIGH: begin
          if (w_last) begin
            if (!r_is_wr) r_rdata <= {bus.sram_dq_in, r_low_half};
            r_state <= DONE;
            r_cnt   <= 4'd0;
            r_we_n  <= 1'b1;
            r_dq_oe <= 1'b0;
          end else begin
            r_cnt   <= w_cnt_nxt;
            r_we_n  <= !w_strobe_cont;
            r_dq_oe <= w_strobe_cont;
          end
        end
        // One-cycle hold so the served instruction's enable cannot re-trigger.
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: word-level memory model vs. SRAM half-word traffic and ready timing.
module tb_mem_stage_sram_ctrl;
  localparam int WW  = 32;
  localparam int SAW = 18;
  localparam int WC  = 5;
`ifdef MEM_ADDR_OFFSET_EN
  localparam bit [31:0] OFF = 32'd1024;
`else
  localparam bit [31:0] OFF = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_sram_ctrl_if #(.WORD_WIDTH(WW), .SRAM_ADDR_WIDTH(SAW)) bus ();

  mem_stage_sram_ctrl #(.WORD_WIDTH(WW), .SRAM_ADDR_WIDTH(SAW), .WAIT_CYCLES(WC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] sram [0:(1<<SAW)-1];
  assign bus.sram_dq_in = sram[bus.sram_addr];
  always @(posedge clk)
    if (!bus.sram_we_n && bus.sram_dq_oe) sram[bus.sram_addr] <= bus.sram_dq_out;

  int          total = 0;
  int          bad   = 0;
  bit [31:0]   model [int];
  bit [31:0]   exp_rdata;
  bit [31:0]   stored_addrs [$];

  function automatic int word_idx(input bit [31:0] a);
    bit [31:0] e;
    e = a - OFF;
    return int'((e / 4) % (32'd1 << (SAW - 1)));
  endfunction

  task automatic access(input bit rd, input bit wr, input bit [31:0] a, input bit [31:0] d, input bit drop);
    int idx;
    bit is_wr;
    bit done;
    int phase, k;
    bit exp_we_n;
    bit [15:0] exp_dq;
    idx   = word_idx(a);
    is_wr = wr;
    done  = 1'b0;
    if (is_wr) model[idx] = d;
    else exp_rdata = model.exists(idx) ? model[idx] : 32'd0;
    bus.MEM_R_EN = rd;
    bus.MEM_W_EN = wr;
    bus.ALU_Res  = a;
    bus.Val_Rm   = d;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (bus.ready) begin
        done = 1'b1;
        total++;
        if (c !== 2*WC+1) begin bad++; $display("FAIL ready_cycle addr=%h: ready rose in cycle %0d, need %0d", a, c, 2*WC+1); end
        total++;
        if (bus.rdata !== exp_rdata) begin bad++; $display("FAIL rdata addr=%h: got %h need %h", a, bus.rdata, exp_rdata); end
      end else if (c >= 1 && c <= 2*WC) begin
        phase    = (c - 1) / WC;
        k        = (c - 1) % WC;
        exp_we_n = is_wr ? (k == WC-1) : 1'b1;
        exp_dq   = phase ? d[31:16] : d[15:0];
        total++;
        if (bus.sram_addr !== SAW'(idx*2 + phase)) begin bad++; $display("FAIL sram_addr cycle %0d: got %0d need %0d", c, bus.sram_addr, idx*2+phase); end
        total++;
        if (bus.sram_we_n !== exp_we_n || bus.sram_dq_oe !== !exp_we_n) begin
          bad++; $display("FAIL strobe cycle %0d: we_n=%b oe=%b need we_n=%b oe=%b", c, bus.sram_we_n, bus.sram_dq_oe, exp_we_n, !exp_we_n);
        end
        if (is_wr) begin
          total++;
          if (bus.sram_dq_out !== exp_dq) begin bad++; $display("FAIL dq_out cycle %0d: got %h need %h", c, bus.sram_dq_out, exp_dq); end
        end
      end
      @(posedge clk); #1;
    end
    if (!done) begin total++; bad++; $display("FAIL timeout addr=%h: ready never rose", a); end
    if (drop) begin bus.MEM_R_EN = 1'b0; bus.MEM_W_EN = 1'b0; end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (bus.ready !== 1'b1 || bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0) begin
        bad++; $display("FAIL reset_ctrl cyc %0d: ready=%b we_n=%b oe=%b need 1 1 0", i, bus.ready, bus.sram_we_n, bus.sram_dq_oe);
      end
      total++;
      if (bus.rdata !== 32'd0 || bus.sram_addr !== '0 || bus.sram_dq_out !== 16'd0) begin
        bad++; $display("FAIL reset_data cyc %0d: rdata=%h addr=%h dq=%h need zeros", i, bus.rdata, bus.sram_addr, bus.sram_dq_out);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b1);
    access(1'b1, 1'b0, 32'd1032, $urandom, 1'b1);
  endtask

  task automatic test_byte_offset();
    access(1'b0, 1'b1, 32'h0000000C, 32'h1234_5678, 1'b1);
    access(1'b1, 1'b0, 32'h0000000E, 32'h0, 1'b1);
  endtask

  task automatic test_back_to_back();
    access(1'b0, 1'b1, 32'h0000_0500, 32'hCAFE_F00D, 1'b1);
    access(1'b1, 1'b0, 32'h0000_0500, 32'h0, 1'b0);
    access(1'b0, 1'b1, 32'h0000_0504, 32'hA5A5_0F0F, 1'b1);
    for (int i = 0; i < 2*WC; i++) begin
      @(negedge clk);
      total++;
      if (bus.ready !== 1'b1 || bus.sram_we_n !== 1'b1) begin
        bad++; $display("FAIL retrigger cyc %0d: ready=%b we_n=%b need 1 1", i, bus.ready, bus.sram_we_n);
      end
    end
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'h0000_0504, 32'h0, 1'b1);
  endtask

  task automatic test_both_enables();
    access(1'b1, 1'b1, 32'h0000_0600, 32'h0BAD_C0DE, 1'b1);
    access(1'b1, 1'b0, 32'h0000_0600, 32'h0, 1'b1);
  endtask

  task automatic test_random();
    bit [31:0] a;
    int op;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      if (op <= 1 || stored_addrs.size() == 0) begin
        a = $urandom;
        stored_addrs.push_back(a);
        access(1'b0, 1'b1, a, $urandom, $urandom_range(0, 1) == 1);
      end else if (op == 2) begin
        a = stored_addrs[$urandom_range(0, stored_addrs.size()-1)] ^ 32'($urandom_range(0, 3));
        access(1'b1, 1'b0, a, $urandom, $urandom_range(0, 1) == 1);
      end else begin
        access(1'b1, 1'b0, $urandom, $urandom, $urandom_range(0, 1) == 1);
      end
    end
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bus.MEM_W_EN = 1'b1;
    bus.MEM_R_EN = 1'b0;
    bus.ALU_Res  = 32'h0000_0700;
    bus.Val_Rm   = 32'h1111_2222;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.sram_we_n !== 1'b0) begin bad++; $display("FAIL mid_pre: we_n=%b need 0 in LOW cycle 3", bus.sram_we_n); end
    rst = 1'b1;
    #1;
    exp_rdata = 32'd0;
    total++;
    if (bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0) begin
      bad++; $display("FAIL mid_rst: we_n=%b oe=%b need 1 0", bus.sram_we_n, bus.sram_dq_oe);
    end
    total++;
    if (bus.rdata !== 32'd0) begin bad++; $display("FAIL mid_rdata: got %h need 0", bus.rdata); end
    bus.MEM_W_EN = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 2*WC+2; i++) begin
      @(negedge clk);
      total++;
      if (bus.ready !== 1'b1 || bus.sram_we_n !== 1'b1 || bus.sram_addr !== '0) begin
        bad++; $display("FAIL mid_after cyc %0d: ready=%b we_n=%b addr=%0d need 1 1 0", i, bus.ready, bus.sram_we_n, bus.sram_addr);
      end
    end
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'h0000_0600, 32'h0, 1'b1);
  endtask

  initial begin
    rst          = 1'b1;
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
    bus.ALU_Res  = 32'd0;
    bus.Val_Rm   = 32'd0;
    exp_rdata    = 32'd0;
    for (int i = 0; i < (1<<SAW); i++) sram[i] = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_store_load();
    test_byte_offset();
    test_back_to_back();
    test_both_enables();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
